// File: rtl/reg_writeback.sv
// Write-side sequencer for the 16x32 register file: merges an always-accepted ALU port and a
// queued multi-cycle port onto one registered write port. Optional scoreboard: WB_SCOREBOARD_EN.
module reg_writeback #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        a_valid,
  input  logic [3:0]                  a_dest,
  input  logic [31:0]                 a_data,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [3:0]                  b_dest,
  input  logic [31:0]                 b_data,
  input  logic                        issue_valid,
  input  logic [3:0]                  issue_dest,
  input  logic [3:0]                  src_one,
  input  logic [3:0]                  src_two,
  output logic                        busy_one,
  output logic                        busy_two,
  output logic [3:0]                  rf_dest,
  output logic                        rf_write_enable,
  output logic [31:0]                 rf_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

  logic [3:0]    fifo_dest [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  logic          fifo_empty;
  logic          fifo_full;
  logic          b_accept;
  logic          enq;
  logic          deq;
  logic          direct;
  logic          sel_valid;
  logic [3:0]    sel_dest;
  logic [31:0]   sel_data;
  logic          commit;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_CNT);
  assign b_ready    = !fifo_full;
  assign b_accept   = b_valid && b_ready;
  assign fifo_count = count;

  // Write selection: ALU first, then the queue head, then B straight through when the queue is empty.
  always_comb begin
    sel_valid = 1'b0;
    sel_dest  = 4'd0;
    sel_data  = 32'd0;
    deq       = 1'b0;
    direct    = 1'b0;
    if (a_valid) begin
      sel_valid = 1'b1;
      sel_dest  = a_dest;
      sel_data  = a_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_dest  = fifo_dest[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
      deq       = 1'b1;
    end else if (b_valid) begin
      sel_valid = 1'b1;
      sel_dest  = b_dest;
      sel_data  = b_data;
      direct    = 1'b1;
    end
  end

  assign enq    = b_accept && !direct;
  assign commit = sel_valid && (sel_dest != 4'd0);

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_dest[wr_ptr] <= b_dest;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  // Pointers wrap for free because the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_write_enable <= 1'b0;
      rf_dest         <= 4'd0;
      rf_data         <= 32'd0;
    end else begin
      rf_write_enable <= commit;
      if (commit) begin
        rf_dest <= sel_dest;
        rf_data <= sel_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [15:0] pending;
  logic [15:0] set_mask;
  logic [15:0] clr_mask;

  always_comb begin
    set_mask = 16'd0;
    clr_mask = 16'd0;
    if (issue_valid && issue_dest != 4'd0) set_mask = 16'd1 << issue_dest;
    if (commit) clr_mask = 16'd1 << sel_dest;
  end

  // Clearing before setting lets a re-issue win over the write it overlaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= 16'd0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

  assign busy_one = pending[src_one];
  assign busy_two = pending[src_two];
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_dest, src_one, src_two};
  assign busy_one = 1'b0;
  assign busy_two = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a behavioural model of the write port predicts each
// register file write, queues it, and compares it against the strobe the DUT produces.
module tb_reg_writeback;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid;
  logic [3:0]    a_dest;
  logic [31:0]   a_data;
  logic          b_valid;
  logic          b_ready;
  logic [3:0]    b_dest;
  logic [31:0]   b_data;
  logic          issue_valid;
  logic [3:0]    issue_dest;
  logic [3:0]    src_one;
  logic [3:0]    src_two;
  logic          busy_one;
  logic          busy_two;
  logic [3:0]    rf_dest;
  logic          rf_write_enable;
  logic [31:0]   rf_data;
  logic [CW-1:0] fifo_count;

  int          numCompared = 0;
  int          numMismatched = 0;
  wr_t         modelFifo[$];
  wr_t         expQ[$];
  logic [15:0] modelPend = 16'd0;

  reg_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .src_one(src_one), .src_two(src_two), .busy_one(busy_one), .busy_two(busy_two),
    .rf_dest(rf_dest), .rf_write_enable(rf_write_enable), .rf_data(rf_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic expBusy(input logic [3:0] src);
`ifdef WB_SCOREBOARD_EN
    return modelPend[src];
`else
    return 1'b0;
`endif
  endfunction

  // Drives one cycle of stimulus, predicts the outcome from the model, clocks, then checks.
  task automatic applyStimulus(input logic av, input logic [3:0] ad, input logic [31:0] adt,
                               input logic bv, input logic [3:0] bd, input logic [31:0] bdt,
                               input logic iv, input logic [3:0] id, output logic handshake);
    logic accept;
    logic have;
    logic direct;
    logic expWe;
    wr_t  sel;
    wr_t  got;
    a_valid = av; a_dest = ad; a_data = adt;
    b_valid = bv; b_dest = bd; b_data = bdt;
    issue_valid = iv; issue_dest = id;
    #1;
    checkOutput("fifo_count", 32'(fifo_count), 32'(modelFifo.size()));
    checkOutput("b_ready", 32'(b_ready), 32'(modelFifo.size() < DEPTH));
    checkOutput("busy_one", 32'(busy_one), 32'(expBusy(src_one)));
    checkOutput("busy_two", 32'(busy_two), 32'(expBusy(src_two)));
    accept = bv && (modelFifo.size() < DEPTH);
    have = 1'b0;
    direct = 1'b0;
    sel = '0;
    if (av) begin
      have = 1'b1; sel = '{dest: ad, data: adt};
    end else if (modelFifo.size() > 0) begin
      have = 1'b1; sel = modelFifo.pop_front();
    end else if (bv) begin
      have = 1'b1; direct = 1'b1; sel = '{dest: bd, data: bdt};
    end
    if (accept && !direct) modelFifo.push_back('{dest: bd, data: bdt});
    expWe = have && (sel.dest != 4'd0);
    if (expWe) begin
      modelPend[sel.dest] = 1'b0;
      expQ.push_back(sel);
    end
    if (iv && id != 4'd0) modelPend[id] = 1'b1;
    handshake = accept;
    @(posedge clk);
    #1;
    checkOutput("rf_write_enable", 32'(rf_write_enable), 32'(expWe));
    if (rf_write_enable === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 32'(rf_dest), 32'hFFFF_FFFF);
      end else begin
        got = expQ.pop_front();
        checkOutput("rf_dest", 32'(rf_dest), 32'(got.dest));
        checkOutput("rf_data", rf_data, got.data);
      end
    end
  endtask

  task automatic idle(input int n);
    logic hs;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, hs);
  endtask

  initial begin
    logic hs;
    int bi;
    reset = 1'b0;
    a_valid = 0; a_dest = 0; a_data = 0;
    b_valid = 0; b_dest = 0; b_data = 0;
    issue_valid = 0; issue_dest = 0;
    src_one = 4'd7; src_two = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_we", 32'(rf_write_enable), 0);
    checkOutput("rst_dest", 32'(rf_dest), 0);
    checkOutput("rst_data", rf_data, 0);
    checkOutput("rst_count", 32'(fifo_count), 0);
    checkOutput("rst_b_ready", 32'(b_ready), 1);
    checkOutput("rst_busy_one", 32'(busy_one), 0);
    checkOutput("rst_busy_two", 32'(busy_two), 0);
    reset = 1'b1;
    $display("[TB] reset released, idling");
    idle(10);

    applyStimulus(1, 4'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, hs);
    checkOutput("a5_dest", 32'(rf_dest), 5);
    checkOutput("a5_data", rf_data, 32'hDEAD_BEEF);
    idle(2);

    $display("[TB] ALU starving the queue");
    bi = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1, 4'(8 + c), 32'hA000_0000 + 32'(c), bi < 6, 4'(bi + 1),
                    32'hB000_0000 + 32'(bi + 1), 0, 0, hs);
      if (hs) bi++;
    end
    checkOutput("fill_count", 32'(fifo_count), 4);
    checkOutput("fill_b_ready", 32'(b_ready), 0);
    for (int k = 0; k < 20 && (bi < 6 || modelFifo.size() > 0); k++) begin
      applyStimulus(0, 0, 0, bi < 6, 4'(bi + 1), 32'hB000_0000 + 32'(bi + 1), 0, 0, hs);
      if (hs) bi++;
    end
    checkOutput("b_all_taken", 32'(bi), 6);
    idle(2);

    $display("[TB] register zero");
    applyStimulus(1, 4'd0, 32'h0000_1234, 0, 0, 0, 0, 0, hs);
    applyStimulus(0, 0, 0, 1, 4'd0, 32'h0000_5678, 0, 0, hs);
    checkOutput("b0_accepted", 32'(hs), 1);
    idle(2);

    $display("[TB] scoreboard");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd7, hs);
`ifdef WB_SCOREBOARD_EN
    checkOutput("busy_set", 32'(busy_one), 1);
`else
    checkOutput("busy_off", 32'(busy_one), 0);
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd0, hs);
    applyStimulus(1, 4'd7, 32'h7777_0001, 0, 0, 0, 0, 0, hs);
    checkOutput("busy_clear", 32'(busy_one), 0);
    applyStimulus(1, 4'd7, 32'h7777_0002, 0, 0, 0, 1, 4'd7, hs);
`ifdef WB_SCOREBOARD_EN
    checkOutput("busy_reissue", 32'(busy_one), 1);
`else
    checkOutput("busy_reissue_off", 32'(busy_one), 0);
`endif
    src_two = 4'd7;
    applyStimulus(0, 0, 0, 1, 4'd7, 32'h7777_0003, 0, 0, hs);
    idle(2);

    $display("[TB] reset with entries queued");
    for (int c = 0; c < 3; c++)
      applyStimulus(1, 4'd2, 32'hC000_0000 + 32'(c), 1, 4'(10 + c), 32'hD000_0000 + 32'(c), 0, 0, hs);
    checkOutput("pre_rst_count", 32'(fifo_count), 3);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_count", 32'(fifo_count), 0);
    checkOutput("async_we", 32'(rf_write_enable), 0);
    checkOutput("async_b_ready", 32'(b_ready), 1);
    a_valid = 0; b_valid = 0; issue_valid = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_hold_we", 32'(rf_write_enable), 0);
    end
    modelFifo.delete();
    modelPend = 16'd0;
    checkOutput("exp_empty_at_reset", 32'(expQ.size()), 0);
    expQ.delete();
    reset = 1'b1;
    idle(2);
    applyStimulus(0, 0, 0, 1, 4'd9, 32'h9999_0009, 0, 0, hs);
    for (int c = 0; c < 5; c++)
      applyStimulus(1, 4'd3, 32'hE000_0000 + 32'(c), 1, 4'(11 + c), 32'hF000_0000 + 32'(c), 0, 0, hs);
    for (int k = 0; k < 10 && modelFifo.size() > 0; k++) idle(1);
    idle(2);
    checkOutput("exp_drained", 32'(expQ.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
